// File: rtl/prog_loader.sv
// Framed byte-stream loader for the accumulator CPU's instruction/data memories.
// Frame: HEADER, COUNT, N DATA bytes, CHECK; holds the CPU off while a frame is open.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              err_clr,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready are both
  // high; in_valid may rise or fall freely, in_ready depends only on the state.

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state, next_state;

  logic              xfer;
  logic              hdr_bad;
  logic              cnt_bad;
  logic              good_frame;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] chk_sum;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] sum_q;
  logic              sel_q;
  logic              done_q;

  assign in_ready   = (state != S_ERR);
  assign xfer       = in_valid && in_ready;
  assign hdr_bad    = (in_data[DATA_W-2:ADDR_W] != '0);
  assign cnt_n      = in_data[ADDR_W:0];
  assign cnt_bad    = (in_data[DATA_W-1:ADDR_W+1] != '0) || (cnt_n == '0) || (cnt_n > MAX_N);
  assign chk_sum    = sum_q + in_data;
  assign good_frame = (state == S_CHECK) && xfer && (chk_sum == '0);

  assign cpu_hold  = (state != S_IDLE);
  assign err       = (state == S_ERR);
  assign done      = done_q;
  assign mem_sel   = sel_q;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (xfer) next_state = hdr_bad ? S_ERR : S_COUNT;
      S_COUNT: if (xfer) next_state = cnt_bad ? S_ERR : S_DATA;
      S_DATA:  if (xfer && remaining == CNT_W'(1)) next_state = S_CHECK;
      S_CHECK: if (xfer) next_state = (chk_sum == '0) ? S_IDLE : S_ERR;
      S_ERR:   if (err_clr) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Write port is registered: a DATA byte taken at edge k is written by MEM at edge k+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q     <= 1'b0;
      addr_q    <= '0;
      remaining <= '0;
      sum_q     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      done_q    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done_q <= good_frame;
      case (state)
        S_IDLE: if (xfer && !hdr_bad) begin
          sel_q  <= in_data[DATA_W-1];
          addr_q <= in_data[ADDR_W-1:0];
        end
        S_COUNT: if (xfer && !cnt_bad) begin
          remaining <= cnt_n;
          sum_q     <= '0;
        end
        S_DATA: if (xfer) begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= addr_q;
          mem_din   <= in_data;
          addr_q    <= addr_q + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
          sum_q     <= chk_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand-written corner sequences
// and random frames scored against a frame-level reference model.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       err_clr = 1'b0;
  logic       mem_sel, mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_din;
  logic       cpu_hold, done, err;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr = 0;
  int prev_wr = 0;

  // {sel, addr, din} of each write still owed by the DUT
  logic [13:0] exp_q[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .err_clr(err_clr), .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .cpu_hold(cpu_hold), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    logic [13:0] e;
    cyc++;
    if (mem_en || mem_we) begin
      wr_count++;
      prev_wr = last_wr;
      last_wr = cyc;
      checks++;
      if (!(mem_en && mem_we)) begin
        failures++;
        $display("FAIL en_we_pair act=%0b%0b exp=11", mem_en, mem_we);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write act=%0h exp=none", {mem_sel, mem_addr, mem_din});
      end else begin
        e = exp_q.pop_front();
        if (e !== {mem_sel, mem_addr, mem_din}) begin
          failures++;
          $display("FAIL write act=%0h exp=%0h", {mem_sel, mem_addr, mem_din}, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] fb[$], input logic exp_done,
                           input int min_gap, input int max_gap, input string name);
    for (int i = 0; i < fb.size(); i++) begin
      if (i > 0 && max_gap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(min_gap, max_gap)) @(negedge clk);
      end
      send_byte(fb[i]);
      if (i == 0) chk({name, "_hold_rise"}, 32'(cpu_hold), 32'(1));
      if (i < fb.size() - 1) chk({name, "_no_early_end"}, 32'(done | err), 32'(0));
    end
    chk({name, "_done"}, 32'(done), 32'(exp_done));
    chk({name, "_err"}, 32'(err), 32'(!exp_done));
    chk({name, "_ready"}, 32'(in_ready), 32'(exp_done));
    chk({name, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    @(negedge clk);
    chk({name, "_done_1cyc"}, 32'(done), 32'(0));
    if (!exp_done) begin
      chk({name, "_err_held"}, 32'(err), 32'(1));
      pulse_clr();
      chk({name, "_clr_err"}, 32'(err), 32'(0));
      chk({name, "_clr_ready"}, 32'(in_ready), 32'(1));
      chk({name, "_clr_hold"}, 32'(cpu_hold), 32'(0));
    end
    chk({name, "_writes_drained"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  // Frame-level reference: decide the outcome from the byte list directly.
  task automatic model(input logic [7:0] fb[$], output logic ok, output int used);
    logic [7:0] s;
    logic [4:0] a;
    int n;
    ok = 1'b0;
    if (fb[0][6:5] != 2'b00) begin
      used = 1;
      return;
    end
    n = int'(fb[1][5:0]);
    if (fb[1][7:6] != 2'b00 || n == 0 || n > 32) begin
      used = 2;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(fb[0][4:0]) + i) % 32);
      exp_q.push_back({fb[0][7], a, fb[2 + i]});
      s = s + fb[2 + i];
    end
    ok = ((int'(s) + int'(fb[n + 2])) % 256) == 0;
    used = n + 3;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b[8];
    int          len;
    logic        exp_done;
    logic [13:0] w[3];
    int          nw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] q[$];
    logic ok;
    int used, kind, n, wc0;
    logic [7:0] hdr, cnt, s, d;

    vecs[0].name = "good_imem";
    vecs[0].b = '{8'h03, 8'h02, 8'hA1, 8'h40, 8'h1F, 8'h00, 8'h00, 8'h00};
    vecs[0].len = 5; vecs[0].exp_done = 1'b1; vecs[0].nw = 2;
    vecs[0].w = '{{1'b0, 5'd3, 8'hA1}, {1'b0, 5'd4, 8'h40}, 14'h0};
    vecs[1].name = "wrap_dmem";
    vecs[1].b = '{8'h9E, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA, 8'h00, 8'h00};
    vecs[1].len = 6; vecs[1].exp_done = 1'b1; vecs[1].nw = 3;
    vecs[1].w = '{{1'b1, 5'd30, 8'h01}, {1'b1, 5'd31, 8'h02}, {1'b1, 5'd0, 8'h03}};
    vecs[2].name = "bad_sum";
    vecs[2].b = '{8'h05, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].len = 4; vecs[2].exp_done = 1'b0; vecs[2].nw = 1;
    vecs[2].w = '{{1'b0, 5'd5, 8'h55}, 14'h0, 14'h0};
    vecs[3].name = "bad_hdr";
    vecs[3].b = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].len = 1; vecs[3].exp_done = 1'b0; vecs[3].nw = 0;
    vecs[3].w = '{14'h0, 14'h0, 14'h0};
    vecs[4].name = "cnt_zero";
    vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].len = 2; vecs[4].exp_done = 1'b0; vecs[4].nw = 0;
    vecs[4].w = '{14'h0, 14'h0, 14'h0};
    vecs[5].name = "cnt_33";
    vecs[5].b = '{8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].len = 2; vecs[5].exp_done = 1'b0; vecs[5].nw = 0;
    vecs[5].w = '{14'h0, 14'h0, 14'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_hold", 32'(cpu_hold), 32'(0));
    chk("rst_outs", {22'b0, done, err, mem_en, mem_we, mem_sel, mem_addr}, 32'(0));
    chk("rst_din", 32'(mem_din), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].b[i]);
      for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(vecs[v].w[i]);
      wc0 = wr_count;
      run_frame(q, vecs[v].exp_done, 0, 0, vecs[v].name);
      chk({vecs[v].name, "_nwrites"}, 32'(wr_count - wc0), 32'(vecs[v].nw));
      if (v == 0) chk("back_to_back", 32'(last_wr - prev_wr), 32'(1));
    end

    // Throttled source: in_valid toggles every cycle
    q.delete();
    q.push_back(8'h00);
    q.push_back(8'h20);
    for (int i = 0; i < 32; i++) begin
      q.push_back(8'(i));
      exp_q.push_back({1'b0, 5'(i), 8'(i)});
    end
    q.push_back(8'h10);
    wc0 = wr_count;
    run_frame(q, 1'b1, 1, 1, "throttle");
    chk("throttle_nwrites", 32'(wr_count - wc0), 32'(32));

    // err_clr outside ERR is ignored
    send_byte(8'h01);
    pulse_clr();
    chk("clr_ignored_hold", 32'(cpu_hold), 32'(1));
    chk("clr_ignored_err", 32'(err), 32'(0));
    q.delete();
    q.push_back(8'h01); q.push_back(8'h77); q.push_back(8'h89);
    exp_q.push_back({1'b0, 5'd1, 8'h77});
    run_frame(q, 1'b1, 0, 0, "clr_ignored");

    // Reset after the 2nd DATA byte of a 4-byte frame
    exp_q.push_back({1'b1, 5'd4, 8'hAA});
    send_byte(8'h84);
    send_byte(8'h04);
    send_byte(8'hAA);
    in_valid = 1'b1;
    in_data  = 8'hBB;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_write", {30'b0, mem_en, mem_we}, 32'(0));
    chk("midrst_outs", {23'b0, done, err, cpu_hold, mem_sel, mem_addr}, 32'(0));
    chk("midrst_din", 32'(mem_din), 32'(0));
    chk("midrst_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_writes", 32'(exp_q.size()), 32'(0));
    q.delete();
    q.push_back(8'h84); q.push_back(8'h02); q.push_back(8'hCC); q.push_back(8'hDD);
    q.push_back(8'h57);
    exp_q.push_back({1'b1, 5'd4, 8'hCC});
    exp_q.push_back({1'b1, 5'd5, 8'hDD});
    run_frame(q, 1'b1, 0, 0, "after_rst");

    // Random frames against the reference model
    repeat (24) begin
      q.delete();
      kind = $urandom_range(0, 9);
      hdr = 8'($urandom_range(0, 255));
      hdr[6:5] = (kind == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      n = $urandom_range(1, 32);
      cnt = 8'(n);
      if (kind == 1) begin
        cnt = 8'($urandom_range(0, 255));
        if (cnt[7:6] == 2'b00 && cnt[5:0] >= 6'd1 && cnt[5:0] <= 6'd32) cnt = 8'h00;
      end
      q.push_back(hdr);
      q.push_back(cnt);
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom_range(0, 255));
        q.push_back(d);
        s = s + d;
      end
      s = 8'h00 - s;
      if (kind == 2) s = s + 8'($urandom_range(1, 255));
      q.push_back(s);
      model(q, ok, used);
      while (q.size() > used) q.pop_back();
      run_frame(q, ok, 0, 2, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program/data loader that writes the accumulator CPU's instruction and data memories from a byte stream. It accepts framed bytes on a valid/ready interface and drives the memories' write-side ports (en/we/addr/din). It holds the CPU off (`cpu_hold`) while a frame is in flight, and reports completion or checksum/format errors. It sits between an external byte source (host link or testbench) and the two MEM instances.

## Interface
- `ADDR_W`, default 5: memory address width (32 words).
- `DATA_W`, default 8: memory word and stream byte width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  DATA_W  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `err_clr`  in  1  single-cycle pulse; clears the error state.
- `mem_sel`  out  1  0 = instruction memory, 1 = data memory.
- `mem_en`  out  1  memory enable for the write.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_din`  out  DATA_W  write data.
- `cpu_hold`  out  1  CPU must stay in reset/stall while high.
- `done`  out  1  one-cycle pulse on a good frame.
- `err`  out  1  level; high while in the ERR state.

## Operation
- Frame order: HEADER, COUNT, N DATA bytes, CHECK.
- HEADER byte fields:
  - bit7 is the target (`mem_sel`).
  - bits 6:5 must be 0.
  - bits 4:0 are the start address.
- COUNT byte: bits 5:0 give N, legal range 1..32. Bits 7:6 must be 0.
- CHECK byte: two's complement of the mod-256 sum of the DATA bytes. The frame is good when (sum(DATA) + CHECK) mod 256 == 0.
- A byte transfers when `in_valid && in_ready` at a rising edge.
- States:
  - IDLE: waits for HEADER. On transfer: if bits 6:5 ≠ 0, go to ERR; otherwise latch sel/addr and go to COUNT.
  - COUNT: on transfer, if N == 0 or N > 32, go to ERR. Otherwise latch `remaining = N`, clear the running sum, and go to DATA.
  - DATA: on each transfer, register a write of the byte to the current address and add the byte to the sum (8-bit wrap). Increment the address modulo 2^ADDR_W (31 → 0) and decrement `remaining`. When `remaining` reaches 0, go to CHECK.
  - CHECK: on transfer, go to IDLE with a `done` pulse if (sum + byte) mod 256 == 0. Otherwise go to ERR.
  - ERR: `in_ready` = 0. `err_clr` returns to IDLE.
- `in_ready` = 1 in IDLE, COUNT, DATA and CHECK; 0 in ERR.
- `cpu_hold` = 1 in every state except IDLE. It therefore stays high through ERR until cleared.
- Memory words written before an error are not rolled back. `err` tells the host to reload.
- A frame may cover the whole memory (N = 32); the addresses wrap.

## Timing
- Reset values: state IDLE, `in_ready` 1, `cpu_hold` 0, `done` 0, `err` 0, `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_din` 0, `mem_sel` 0.
- Memory write outputs are registered. A DATA byte accepted at edge k produces `mem_en` = `mem_we` = 1 with that byte's addr/din during cycle k..k+1, i.e. sampled by MEM at edge k+1. Otherwise `mem_en`/`mem_we` are 0.
- Back-to-back DATA bytes give back-to-back write cycles; there is no bubble. `in_valid` low inserts idle cycles with no write.
- `done` is high for exactly the one cycle after the CHECK byte transfers.
- `err` rises the cycle after the offending byte transfers.
- `cpu_hold` rises the cycle after HEADER is accepted. It falls the cycle after a good CHECK, coincident with `done`.
- If `err_clr` is asserted outside ERR, it is ignored.
- Asynchronous reset mid-frame:
  - returns immediately to reset values and discards the partial frame;
  - suppresses any write in progress;
  - leaves already-written words as they are.

## Test plan
- Good instruction frame 03,02,A1,40,1F: writes imem[3]=A1 then imem[4]=40 on consecutive cycles (`mem_sel` 0); then `done` pulses for 1 cycle and `cpu_hold` falls.
- Wrap frame 9E,03,01,02,03,FA: writes dmem[30]=01, dmem[31]=02, dmem[0]=03 (`mem_sel` 1); then `done`.
- Bad checksum 05,01,55,00:
  - dmem is not involved; imem[5]=55 is written;
  - `err` = 1, `in_ready` = 0, `cpu_hold` stays 1;
  - after an `err_clr` pulse: IDLE, `in_ready` 1, `cpu_hold` 0.
- Format errors:
  - header 60 goes to ERR after the header;
  - count 00 goes to ERR after the count byte;
  - count 21 goes to ERR after the count byte;
  - no `mem_we` ever asserted in any of these.
- Throttled source: frame 00,20 followed by 32 bytes 00..1F and CHECK 10, with `in_valid` toggling every cycle. Requires exactly 32 writes (imem[i]=i), no write in idle cycles, and `done`.
- Reset asserted after the 2nd DATA byte of a 4-byte frame: all outputs return to reset values immediately. A following good frame completes normally.
